nbit_mux_pipe_reg: RTL and testbench

- Parametrised successor to the team's N-bit 2:1 mux: an M-input, N-bit selector followed by a registered pipeline stage.
- Uses a valid/ready handshake, a 2-entry skid buffer and a synchronous flush.
- Used between pipeline stages (e.g. forwarding/operand select into ID/EX) where the selected value must be registered and held under back-pressure.

---
 rtl/nbit_mux_pipe_pkg.sv | 15 +
 rtl/nbit_mux_pipe_reg_mto1.sv | 21 ++
 rtl/nbit_mux_pipe_reg.sv | 115 +++++++++++
 tb/tb_nbit_mux_pipe_reg.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/nbit_mux_pipe_pkg.sv
// Shared types and helpers for the M:1 N-bit mux pipeline register.
package nbit_mux_pipe_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Select width for an m-input mux; never narrower than one bit.
    function automatic int sel_width(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/nbit_mux_pipe_reg_mto1.sv
// Purely combinational M:1 N-bit selector; out-of-range select yields zero.
module nbit_mux_mto1
    import nbit_mux_pipe_pkg::*;
#(
    parameter int N     = 32,
    parameter int M     = 4,
    parameter int SEL_W = sel_width(M)
) (
    input  logic [M*N-1:0] in_data,
    input  logic [SEL_W-1:0] sel,
    output logic [N-1:0]   chosen
);

    always_comb begin
        chosen = '0;
        for (int k = 0; k < M; k++) begin
            if (int'(sel) == k) chosen = in_data[k*N +: N];
        end
    end

endmodule

// File: rtl/nbit_mux_pipe_reg.sv
// M-input N-bit selector feeding a registered valid/ready stage with a 2-entry skid buffer.
// Optional out-of-range select flag enabled by NBIT_MUX_PIPE_SEL_CHECK_EN.
module nbit_mux_pipe_reg
    import nbit_mux_pipe_pkg::*;
#(
    parameter int N     = 32,
    parameter int M     = 4,
    parameter int SEL_W = sel_width(M)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [M*N-1:0]   in_data,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             flush,
    output logic [N-1:0]     out_data,
    output logic [SEL_W-1:0] out_sel,
    output logic             out_valid,
    input  logic             out_ready
`ifdef NBIT_MUX_PIPE_SEL_CHECK_EN
    ,output logic            out_sel_err
`endif
);

    state_t           state, next_state;
    logic [N-1:0]     chosen, main_data, skid_data;
    logic [SEL_W-1:0] main_sel, skid_sel;
    logic             ready_q;
    logic             accept, xfer, load_main, load_skid, promote;

    nbit_mux_mto1 #(.N(N), .M(M), .SEL_W(SEL_W)) u_mux (
        .in_data (in_data),
        .sel     (in_sel),
        .chosen  (chosen)
    );

    assign accept = in_valid && ready_q;
    assign xfer   = (state != EMPTY) && out_ready;

    always_comb begin
        next_state = state;
        case (state)
            EMPTY:   if (accept) next_state = ONE;
            ONE: begin
                if (accept && !xfer)      next_state = TWO;
                else if (!accept && xfer) next_state = EMPTY;
            end
            TWO:     if (xfer) next_state = ONE;
            default: next_state = EMPTY;
        endcase
        if (flush) next_state = EMPTY;
    end

    // Flush freezes the data registers; only the occupancy state is cleared.
    assign load_main = !flush && accept && ((state == EMPTY) || (state == ONE && xfer));
    assign load_skid = !flush && accept && (state == ONE) && !xfer;
    assign promote   = !flush && (state == TWO) && xfer;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= EMPTY;
            ready_q   <= 1'b1;
            main_data <= '0;
            main_sel  <= '0;
            skid_data <= '0;
            skid_sel  <= '0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state != TWO);
            if (load_main) begin
                main_data <= chosen;
                main_sel  <= in_sel;
            end else if (promote) begin
                main_data <= skid_data;
                main_sel  <= skid_sel;
            end
            if (load_skid) begin
                skid_data <= chosen;
                skid_sel  <= in_sel;
            end
        end
    end

    assign in_ready  = ready_q;
    assign out_valid = (state != EMPTY);
    assign out_data  = main_data;
    assign out_sel   = main_sel;

`ifdef NBIT_MUX_PIPE_SEL_CHECK_EN
    logic sel_oob, main_err, skid_err;

    assign sel_oob = (int'(in_sel) >= M);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_err <= 1'b0;
            skid_err <= 1'b0;
        end else if (flush) begin
            main_err <= 1'b0;
            skid_err <= 1'b0;
        end else begin
            if (load_main)    main_err <= sel_oob;
            else if (promote) main_err <= skid_err;
            if (load_skid)    skid_err <= sel_oob;
        end
    end

    assign out_sel_err = main_err;

    a_sel_range: assert property (@(posedge clk) disable iff (!rst)
        !(in_valid && in_ready && sel_oob));
`endif

endmodule

// File: tb/tb_nbit_mux_pipe_reg.sv
// Directed + scoreboarded checks of nbit_mux_pipe_reg (M=4 main instance, M=3 for out-of-range select).
module tb_nbit_mux_pipe_reg;

    logic         clk = 1'b0;
    logic         rst;
    logic [127:0] in_data;
    logic [1:0]   in_sel;
    logic         in_valid, in_ready, flush, out_valid, out_ready;
    logic [31:0]  out_data;
    logic [1:0]   out_sel;

    logic [95:0]  d3_in_data;
    logic [1:0]   d3_in_sel, d3_out_sel;
    logic         d3_in_valid, d3_in_ready, d3_flush, d3_out_valid, d3_out_ready;
    logic [31:0]  d3_out_data;
`ifdef NBIT_MUX_PIPE_SEL_CHECK_EN
    logic         err4, err3;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nbit_mux_pipe_reg #(.N(32), .M(4)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_sel(in_sel),
        .in_valid(in_valid), .in_ready(in_ready), .flush(flush),
        .out_data(out_data), .out_sel(out_sel), .out_valid(out_valid),
        .out_ready(out_ready)
`ifdef NBIT_MUX_PIPE_SEL_CHECK_EN
        ,.out_sel_err(err4)
`endif
    );

    nbit_mux_pipe_reg #(.N(32), .M(3)) dut3 (
        .clk(clk), .rst(rst), .in_data(d3_in_data), .in_sel(d3_in_sel),
        .in_valid(d3_in_valid), .in_ready(d3_in_ready), .flush(d3_flush),
        .out_data(d3_out_data), .out_sel(d3_out_sel), .out_valid(d3_out_valid),
        .out_ready(d3_out_ready)
`ifdef NBIT_MUX_PIPE_SEL_CHECK_EN
        ,.out_sel_err(err3)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [1:0] sel, input logic [31:0] d);
        in_data = '0;
        in_data[sel*32 +: 32] = d;
        in_sel   = sel;
        in_valid = 1'b1;
        tick();
    endtask

    logic [33:0] q[$];
    logic [33:0] exp_beat;
    int sent, rcvd;
    logic acc, xf;

    initial begin
        rst = 1'b0; in_data = '0; in_sel = '0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        d3_in_data = '0; d3_in_sel = '0; d3_in_valid = 1'b0; d3_flush = 1'b0; d3_out_ready = 1'b1;
        #12;
        chk("rst_valid", out_valid, 0);
        chk("rst_data",  out_data, 0);
        chk("rst_sel",   out_sel, 0);
        chk("rst_ready", in_ready, 1);
        @(negedge clk) rst = 1'b1;
        tick();

        // Basic select
        out_ready = 1'b1;
        send(2'd2, 32'hDEADBEEF);
        chk("basic_data",  out_data, 32'hDEADBEEF);
        chk("basic_sel",   out_sel, 2);
        chk("basic_valid", out_valid, 1);
        in_valid = 1'b0;
        tick();
        chk("basic_drain", out_valid, 0);

        // Back-pressure into the skid buffer
        out_ready = 1'b0;
        send(2'd0, 32'h11);
        chk("bp_one_data",  out_data, 32'h11);
        chk("bp_one_ready", in_ready, 1);
        send(2'd1, 32'h22);
        chk("bp_two_ready", in_ready, 0);
        chk("bp_two_data",  out_data, 32'h11);
        in_valid = 1'b0;
        tick();
        chk("bp_hold_data",  out_data, 32'h11);
        chk("bp_hold_sel",   out_sel, 0);
        chk("bp_hold_valid", out_valid, 1);
        out_ready = 1'b1;
        tick();
        chk("bp_second_data", out_data, 32'h22);
        chk("bp_second_sel",  out_sel, 1);
        chk("bp_second_rdy",  in_ready, 1);
        tick();
        chk("bp_empty", out_valid, 0);

        // Flush from TWO with a same-cycle input beat
        out_ready = 1'b0;
        send(2'd0, 32'h33);
        send(2'd1, 32'h44);
        chk("fl_two_ready", in_ready, 0);
        in_data = '0; in_data[95:64] = 32'h55; in_sel = 2'd2; in_valid = 1'b1; flush = 1'b1;
        tick();
        chk("fl_valid", out_valid, 0);
        chk("fl_ready", in_ready, 1);
        chk("fl_data_hold", out_data, 32'h33);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("fl_no_ghost", out_valid, 0);
        end

        // Async reset mid-operation from TWO
        out_ready = 1'b0;
        send(2'd3, 32'h66);
        send(2'd1, 32'h77);
        in_valid = 1'b0;
        chk("ar_two_ready", in_ready, 0);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_ready", in_ready, 1);
        chk("ar_data",  out_data, 0);
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        chk("ar_no_survivor", out_valid, 0);

        // Out-of-range select on the M=3 instance
        d3_in_data = '1; d3_in_sel = 2'd3; d3_in_valid = 1'b1;
        tick();
        chk("oor_data",  d3_out_data, 0);
        chk("oor_sel",   d3_out_sel, 3);
        chk("oor_valid", d3_out_valid, 1);
`ifdef NBIT_MUX_PIPE_SEL_CHECK_EN
        chk("oor_err", err3, 1);
`endif
        d3_in_data = {32'h0, 32'hA5A5A5A5, 32'h0}; d3_in_sel = 2'd1;
        tick();
        chk("inr_data", d3_out_data, 32'hA5A5A5A5);
        chk("inr_sel",  d3_out_sel, 1);
`ifdef NBIT_MUX_PIPE_SEL_CHECK_EN
        chk("inr_err", err3, 0);
`endif
        d3_in_valid = 1'b0;

        // Streaming against a scoreboard with random back-pressure
        sent = 0; rcvd = 0;
        in_data  = {$urandom, $urandom, $urandom, $urandom};
        in_sel   = 2'($urandom_range(0, 3));
        in_valid = 1'b1;
        for (int cyc = 0; cyc < 2000 && rcvd < 100; cyc++) begin
            out_ready = 1'($urandom_range(0, 1));
            chk("strm_valid", out_valid, (q.size() != 0));
            chk("strm_ready", in_ready, (q.size() < 2));
            acc = in_valid && in_ready;
            xf  = out_valid && out_ready;
            if (xf) begin
                exp_beat = (q.size() != 0) ? q.pop_front() : 34'h0;
                chk("strm_data", out_data, exp_beat[31:0]);
                chk("strm_sel",  out_sel, exp_beat[33:32]);
                rcvd++;
            end
            if (acc) begin
                q.push_back({in_sel, in_data[in_sel*32 +: 32]});
                sent++;
            end
            tick();
            if (acc) begin
                if (sent < 100) begin
                    in_data = {$urandom, $urandom, $urandom, $urandom};
                    in_sel  = 2'($urandom_range(0, 3));
                end else begin
                    in_valid = 1'b0;
                end
            end
        end
        chk("strm_count", rcvd, 100);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
